// File: rtl/pmem_scheduler.sv
// pmem_scheduler: arbitrates the single cacheline adaptor port between the
// dcache, the icache and the next-line prefetcher. Fixed priority
// dcache > icache > prefetch, with an icache anti-starvation override.
// One transaction at a time, no preemption; request fields are latched at grant.
module pmem_scheduler #(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned LINE_W     = 256,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   // dcache
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_address,
   input  logic [LINE_W-1:0] d_wdata,
   output logic              d_resp,
   output logic [LINE_W-1:0] d_rdata,
   // icache
   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_address,
   output logic              i_resp,
   output logic [LINE_W-1:0] i_rdata,
   // prefetcher
   input  logic              p_read,
   input  logic [ADDR_W-1:0] p_address,
   output logic              p_resp,
   output logic [LINE_W-1:0] p_rdata,
   // cacheline adaptor
   output logic              m_read,
   output logic              m_write,
   output logic [ADDR_W-1:0] m_address,
   output logic [LINE_W-1:0] m_wdata,
   input  logic              m_resp,
   input  logic [LINE_W-1:0] m_rdata,
   // status
   output logic [1:0]        grant_id,
   output logic              busy
);

   localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

   localparam logic [1:0] G_NONE = 2'b00;
   localparam logic [1:0] G_D    = 2'b01;
   localparam logic [1:0] G_I    = 2'b10;
   localparam logic [1:0] G_P    = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_GRANT   = 2'd1,
      S_RECOVER = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [1:0]          grant_q, grant_d;
   logic                m_read_q, m_read_d;
   logic                m_write_q, m_write_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [LINE_W-1:0]   wdata_q, wdata_d;
   logic [CNT_W-1:0]    starve_q, starve_d;
   logic [1:0]          sel_c;
   logic                done_c;

   // Winner selection among live requests, with the starvation override first
   always_comb begin
      sel_c = G_NONE;
      if ((starve_q == STARVE_LIM) && i_read) begin
         sel_c = G_I;
      end else if (d_read || d_write) begin
         sel_c = G_D;
      end else if (i_read) begin
         sel_c = G_I;
      end else if (p_read) begin
         sel_c = G_P;
      end
   end

   // Next-state, latched request fields and starve counter
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      m_read_d  = m_read_q;
      m_write_d = m_write_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      starve_d  = starve_q;
      case (state_q)
         S_IDLE: begin
            if (!i_read) begin
               starve_d = '0;
            end
            case (sel_c)
               G_D: begin
                  state_d   = S_GRANT;
                  grant_d   = G_D;
                  // read+write together is illegal; it is served as a write
                  m_write_d = d_write;
                  m_read_d  = !d_write;
                  addr_d    = d_address;
                  wdata_d   = d_wdata;
                  if (i_read && (starve_q != STARVE_LIM)) begin
                     starve_d = starve_q + CNT_W'(1);
                  end
               end
               G_I: begin
                  state_d   = S_GRANT;
                  grant_d   = G_I;
                  m_read_d  = 1'b1;
                  m_write_d = 1'b0;
                  addr_d    = i_address;
                  wdata_d   = '0;
                  starve_d  = '0;
               end
               G_P: begin
                  state_d   = S_GRANT;
                  grant_d   = G_P;
                  m_read_d  = 1'b1;
                  m_write_d = 1'b0;
                  addr_d    = p_address;
                  wdata_d   = '0;
               end
               default: begin
                  state_d = S_IDLE;
               end
            endcase
         end
         S_GRANT: begin
            if (m_resp) begin
               state_d   = S_RECOVER;
               grant_d   = G_NONE;
               m_read_d  = 1'b0;
               m_write_d = 1'b0;
               addr_d    = '0;
               wdata_d   = '0;
            end
         end
         S_RECOVER: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and latched-request registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         grant_q   <= G_NONE;
         m_read_q  <= 1'b0;
         m_write_q <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         starve_q  <= '0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         m_read_q  <= m_read_d;
         m_write_q <= m_write_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         starve_q  <= starve_d;
      end
   end

   // Completion is steered to the granted requester in the m_resp cycle itself
   always_comb begin
      done_c  = (state_q == S_GRANT) && m_resp;
      d_resp  = done_c && (grant_q == G_D);
      i_resp  = done_c && (grant_q == G_I);
      p_resp  = done_c && (grant_q == G_P);
      d_rdata = d_resp ? m_rdata : '0;
      i_rdata = i_resp ? m_rdata : '0;
      p_rdata = p_resp ? m_rdata : '0;
   end

   assign m_read    = m_read_q;
   assign m_write   = m_write_q;
   assign m_address = addr_q;
   assign m_wdata   = wdata_q;
   assign grant_id  = grant_q;
   assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_pmem_scheduler.sv
// Directed bench for pmem_scheduler: a table of single transactions plus
// hand-written sequences for ordering, starvation, reset and prefetch drop.
module tb_pmem_scheduler;

   localparam int unsigned AW = 32;
   localparam int unsigned LW = 256;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          d_read, d_write, i_read, p_read, m_resp;
   logic [AW-1:0] d_address, i_address, p_address, m_address;
   logic [LW-1:0] d_wdata, m_rdata, m_wdata, d_rdata, i_rdata, p_rdata;
   logic          d_resp, i_resp, p_resp, m_read, m_write, busy;
   logic [1:0]    grant_id;

   int errors = 0;
   int checks = 0;

   pmem_scheduler #(.ADDR_W(AW), .LINE_W(LW), .STARVE_MAX(4)) dut (
      .clk(clk), .reset_n(reset_n),
      .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
      .d_resp(d_resp), .d_rdata(d_rdata),
      .i_read(i_read), .i_address(i_address), .i_resp(i_resp), .i_rdata(i_rdata),
      .p_read(p_read), .p_address(p_address), .p_resp(p_resp), .p_rdata(p_rdata),
      .m_read(m_read), .m_write(m_write), .m_address(m_address), .m_wdata(m_wdata),
      .m_resp(m_resp), .m_rdata(m_rdata),
      .grant_id(grant_id), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          dr, dw;
      logic [AW-1:0] da;
      logic [LW-1:0] dwd;
      logic          ir;
      logic [AW-1:0] ia;
      logic          pr;
      logic [AW-1:0] pa;
      int            rc;
      logic [LW-1:0] rd;
      logic [1:0]    eg;
      logic          emr, emw;
      logic [AW-1:0] ea;
      logic [LW-1:0] ewd;
   } vec_t;

   vec_t vecs[8];

   function automatic vec_t mk(input logic dr, input logic dw, input logic [AW-1:0] da,
                               input logic [LW-1:0] dwd, input logic ir, input logic [AW-1:0] ia,
                               input logic pr, input logic [AW-1:0] pa, input int rc,
                               input logic [LW-1:0] rd, input logic [1:0] eg, input logic emr,
                               input logic emw, input logic [AW-1:0] ea, input logic [LW-1:0] ewd);
      vec_t v;
      v.dr = dr; v.dw = dw; v.da = da; v.dwd = dwd; v.ir = ir; v.ia = ia;
      v.pr = pr; v.pa = pa; v.rc = rc; v.rd = rd; v.eg = eg; v.emr = emr;
      v.emw = emw; v.ea = ea; v.ewd = ewd;
      return v;
   endfunction

   task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_reqs;
      d_read = 1'b0; d_write = 1'b0; i_read = 1'b0; p_read = 1'b0;
   endtask

   // Bounded wait until a grant is visible
   task automatic wait_grant(input string nm);
      int n = 0;
      while (!(busy && grant_id != 2'b00) && n < 20) begin
         tick();
         n++;
      end
      checks++;
      if (n >= 20) begin
         errors++;
         $display("FAIL %s: no grant within 20 cycles", nm);
      end
   endtask

   // From a GRANT cycle: respond after rc grant cycles, end back in IDLE
   task automatic serve(input string nm, input logic [1:0] g, input int rc, input logic [LW-1:0] rd);
      chk({nm, " grant"}, LW'(grant_id), LW'(g));
      for (int k = 0; k < rc - 1; k++) tick();
      m_resp = 1'b1;
      m_rdata = rd;
      #1;
      chk({nm, " d_resp"}, LW'(d_resp), LW'(g == 2'b01));
      chk({nm, " i_resp"}, LW'(i_resp), LW'(g == 2'b10));
      chk({nm, " p_resp"}, LW'(p_resp), LW'(g == 2'b11));
      chk({nm, " rdata"}, (g == 2'b01) ? d_rdata : (g == 2'b10) ? i_rdata : p_rdata, rd);
      tick();
      m_resp = 1'b0;
      m_rdata = '0;
      tick();
   endtask

   initial begin
      logic [LW-1:0] pat_a, pat_b, pat_r;
      logic [1:0]    exp_order[7];
      int            bad, dseen;

      pat_a = {8{32'hA5A5_0001}};
      pat_b = {8{32'h5A5A_0002}};
      pat_r = {8{32'h1234_5678}};

      //               dr    dw    da         dwd    ir    ia         pr    pa         rc rd             eg     mr    mw    ea         ewd
      vecs[0] = mk(1'b0, 1'b0, 32'h0,     '0,    1'b1, 32'h60,    1'b0, 32'h0,     4, pat_r,         2'b10, 1'b1, 1'b0, 32'h60,    '0);
      vecs[1] = mk(1'b1, 1'b0, 32'h200,   '0,    1'b0, 32'h0,     1'b0, 32'h0,     1, ~pat_r,        2'b01, 1'b1, 1'b0, 32'h200,   '0);
      vecs[2] = mk(1'b0, 1'b1, 32'h100,   pat_a, 1'b1, 32'h40,    1'b0, 32'h0,     2, pat_b,         2'b01, 1'b0, 1'b1, 32'h100,   pat_a);
      vecs[3] = mk(1'b1, 1'b1, 32'h300,   pat_b, 1'b0, 32'h0,     1'b0, 32'h0,     3, pat_a,         2'b01, 1'b0, 1'b1, 32'h300,   pat_b);
      vecs[4] = mk(1'b0, 1'b0, 32'h0,     '0,    1'b0, 32'h0,     1'b1, 32'h80,    2, {8{32'hCAFE_F00D}}, 2'b11, 1'b1, 1'b0, 32'h80, '0);
      vecs[5] = mk(1'b0, 1'b0, 32'h0,     '0,    1'b1, 32'hC0,    1'b1, 32'h80,    1, pat_b,         2'b10, 1'b1, 1'b0, 32'hC0,    '0);
      vecs[6] = mk(1'b1, 1'b0, 32'h140,   pat_a, 1'b0, 32'h0,     1'b1, 32'hA0,    2, pat_a,         2'b01, 1'b1, 1'b0, 32'h140,   pat_a);
      vecs[7] = mk(1'b1, 1'b0, 32'h180,   pat_b, 1'b1, 32'h1C0,   1'b1, 32'hE0,    3, pat_r,         2'b01, 1'b1, 1'b0, 32'h180,   pat_b);

      reset_n = 1'b0;
      clear_reqs();
      d_address = '0; i_address = '0; p_address = '0; d_wdata = '0;
      m_resp = 1'b0; m_rdata = '0;
      #1;
      chk("rst m_read", LW'(m_read), LW'(1'b0));
      chk("rst m_write", LW'(m_write), LW'(1'b0));
      chk("rst grant_id", LW'(grant_id), LW'(2'b00));
      chk("rst busy", LW'(busy), LW'(1'b0));
      chk("rst m_address", LW'(m_address), LW'(32'h0));
      chk("rst d_rdata", d_rdata, '0);
      @(negedge clk);
      reset_n = 1'b1;
      tick();

      // Table: one transaction per record; request fields are scrambled during GRANT
      for (int i = 0; i < 8; i++) begin
         d_read = vecs[i].dr; d_write = vecs[i].dw; d_address = vecs[i].da; d_wdata = vecs[i].dwd;
         i_read = vecs[i].ir; i_address = vecs[i].ia;
         p_read = vecs[i].pr; p_address = vecs[i].pa;
         chk($sformatf("v%0d idle busy", i), LW'(busy), LW'(1'b0));
         tick();
         chk($sformatf("v%0d grant_id", i), LW'(grant_id), LW'(vecs[i].eg));
         chk($sformatf("v%0d m_read", i), LW'(m_read), LW'(vecs[i].emr));
         chk($sformatf("v%0d m_write", i), LW'(m_write), LW'(vecs[i].emw));
         chk($sformatf("v%0d m_address", i), LW'(m_address), LW'(vecs[i].ea));
         chk($sformatf("v%0d m_wdata", i), m_wdata, vecs[i].ewd);
         chk($sformatf("v%0d busy", i), LW'(busy), LW'(1'b1));
         clear_reqs();
         d_address = 32'hDEAD_0000; i_address = 32'hDEAD_0004; p_address = 32'hDEAD_0008;
         d_wdata = ~vecs[i].dwd;
         for (int k = 0; k < vecs[i].rc - 1; k++) tick();
         chk($sformatf("v%0d held m_address", i), LW'(m_address), LW'(vecs[i].ea));
         chk($sformatf("v%0d held m_read", i), LW'(m_read), LW'(vecs[i].emr));
         m_resp = 1'b1;
         m_rdata = vecs[i].rd;
         #1;
         chk($sformatf("v%0d d_resp", i), LW'(d_resp), LW'(vecs[i].eg == 2'b01));
         chk($sformatf("v%0d i_resp", i), LW'(i_resp), LW'(vecs[i].eg == 2'b10));
         chk($sformatf("v%0d p_resp", i), LW'(p_resp), LW'(vecs[i].eg == 2'b11));
         chk($sformatf("v%0d d_rdata", i), d_rdata, (vecs[i].eg == 2'b01) ? vecs[i].rd : '0);
         chk($sformatf("v%0d i_rdata", i), i_rdata, (vecs[i].eg == 2'b10) ? vecs[i].rd : '0);
         chk($sformatf("v%0d p_rdata", i), p_rdata, (vecs[i].eg == 2'b11) ? vecs[i].rd : '0);
         tick();
         m_resp = 1'b0;
         m_rdata = '0;
         chk($sformatf("v%0d recover grant_id", i), LW'(grant_id), LW'(2'b00));
         chk($sformatf("v%0d recover m_rw", i), LW'({m_read, m_write}), LW'(2'b00));
         chk($sformatf("v%0d recover busy", i), LW'(busy), LW'(1'b1));
         chk($sformatf("v%0d recover resp", i), LW'({d_resp, i_resp, p_resp}), LW'(3'b000));
         tick();
         chk($sformatf("v%0d back idle", i), LW'(busy), LW'(1'b0));
      end

      // dcache write and icache read together: dcache first, then icache after RECOVER
      d_write = 1'b1; d_address = 32'h100; d_wdata = pat_a;
      i_read = 1'b1; i_address = 32'h40;
      tick();
      chk("order d m_write", LW'(m_write), LW'(1'b1));
      chk("order d m_wdata", m_wdata, pat_a);
      d_write = 1'b0;
      serve("order d", 2'b01, 2, pat_b);
      wait_grant("order i");
      chk("order i m_read", LW'(m_read), LW'(1'b1));
      chk("order i m_address", LW'(m_address), LW'(32'h40));
      i_read = 1'b0;
      serve("order i", 2'b10, 2, pat_r);

      // Starvation: dcache held busy while icache waits; icache wins after four dcache grants
      exp_order = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01};
      d_read = 1'b1; d_address = 32'h400; i_read = 1'b1; i_address = 32'h440;
      for (int t = 0; t < 7; t++) begin
         wait_grant($sformatf("starve t%0d", t));
         chk($sformatf("starve order t%0d", t), LW'(grant_id), LW'(exp_order[t]));
         if (grant_id == 2'b10) i_read = 1'b0;
         if (t == 6) d_read = 1'b0;
         serve($sformatf("starve t%0d", t), grant_id, 2, pat_a ^ LW'(t));
      end

      // Prefetch granted alone runs to completion though dcache arrives right after
      p_read = 1'b1; p_address = 32'h80;
      tick();
      p_read = 1'b0;
      d_read = 1'b1; d_address = 32'h180;
      tick();
      chk("pf hold grant", LW'(grant_id), LW'(2'b11));
      chk("pf hold m_address", LW'(m_address), LW'(32'h80));
      serve("pf", 2'b11, 2, pat_b);
      wait_grant("pf then d");
      chk("pf then d m_address", LW'(m_address), LW'(32'h180));
      d_read = 1'b0;
      serve("pf then d", 2'b01, 1, pat_a);

      // Asynchronous reset mid-GRANT, then a normal dcache read
      d_read = 1'b1; d_address = 32'h40;
      tick();
      d_read = 1'b0;
      chk("rst mid m_read before", LW'(m_read), LW'(1'b1));
      #2;
      reset_n = 1'b0;
      #1;
      chk("rst mid m_read", LW'(m_read), LW'(1'b0));
      chk("rst mid m_write", LW'(m_write), LW'(1'b0));
      chk("rst mid grant_id", LW'(grant_id), LW'(2'b00));
      chk("rst mid busy", LW'(busy), LW'(1'b0));
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      d_read = 1'b1; d_address = 32'h1C0;
      tick();
      chk("post rst m_read", LW'(m_read), LW'(1'b1));
      chk("post rst m_address", LW'(m_address), LW'(32'h1C0));
      d_read = 1'b0;
      serve("post rst", 2'b01, 3, pat_r);

      // One-cycle prefetch pulse during a dcache GRANT must never be served
      d_read = 1'b1; d_address = 32'h20;
      tick();
      d_read = 1'b0;
      p_read = 1'b1; p_address = 32'hA0;
      tick();
      p_read = 1'b0;
      bad = 0;
      dseen = 0;
      for (int c = 0; c < 8; c++) begin
         m_resp = (c == 1);
         m_rdata = pat_a;
         #1;
         if (grant_id == 2'b11 || p_resp) bad++;
         if (d_resp) dseen++;
         tick();
      end
      m_resp = 1'b0;
      chk("pf drop no prefetch", LW'(bad), LW'(0));
      chk("pf drop d_resp count", LW'(dseen), LW'(1));
      chk("pf drop idle", LW'(busy), LW'(1'b0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
